// File: rtl/pc_sequencer.sv
// Fetch-stage program counter: sequential/branch/jump/call/return sequencing with a
// circular return-address stack, exception vectoring and target alignment checking.
module pc_sequencer #(
    parameter int              WIDTH        = 32,
    parameter int              INSTR_BYTES  = 4,
    parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
    parameter logic [WIDTH-1:0] EXC_VECTOR   = 'h80,
    parameter int              RAS_DEPTH    = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [2:0]                       op,
    input  logic                             stall,
    input  logic                             exc,
    input  logic [WIDTH-1:0]                 offset,
    input  logic [WIDTH-1:0]                 target,
    output logic [WIDTH-1:0]                 pc,
    output logic [WIDTH-1:0]                 pc_seq,
    output logic                             redirect,
    output logic                             misalign,
    output logic                             ras_underflow,
    output logic [$clog2(RAS_DEPTH+1)-1:0]   ras_count
);

    localparam int CW = $clog2(RAS_DEPTH + 1);
    localparam int PW = $clog2(RAS_DEPTH);
    localparam logic [WIDTH-1:0] ALIGN_MASK = WIDTH'(INSTR_BYTES - 1);
    localparam logic [WIDTH-1:0] STEP       = WIDTH'(INSTR_BYTES);

    typedef enum logic [2:0] {
        OP_SEQ      = 3'b000,
        OP_BRANCH   = 3'b001,
        OP_JUMP     = 3'b010,
        OP_CALL     = 3'b011,
        OP_RET      = 3'b100,
        OP_HOLD     = 3'b101,
        OP_RELOAD   = 3'b110,
        OP_RESERVED = 3'b111
    } op_e;

    op_e              op_cmd;
    logic [WIDTH-1:0] ras_mem [RAS_DEPTH];
    logic [PW-1:0]    ras_top;
    logic [PW-1:0]    top_inc;
    logic [PW-1:0]    top_dec;

    logic [WIDTH-1:0] pc_next;
    logic [WIDTH-1:0] dest;
    logic [PW-1:0]    top_next;
    logic [CW-1:0]    count_next;
    logic             check_dest;
    logic             push_req;
    logic             push;
    logic             pop;
    logic             clear_ras;
    logic             redirect_next;
    logic             misalign_next;
    logic             underflow_next;

    assign op_cmd = op_e'(op);
    assign pc_seq = pc + STEP;

    // Pointer arithmetic wraps explicitly so non-power-of-two depths stay circular.
    assign top_inc = (ras_top == PW'(RAS_DEPTH - 1)) ? '0 : ras_top + 1'b1;
    assign top_dec = (ras_top == '0) ? PW'(RAS_DEPTH - 1) : ras_top - 1'b1;

    always_comb begin
        pc_next        = pc;
        dest           = pc;
        check_dest     = 1'b0;
        push_req       = 1'b0;
        push           = 1'b0;
        pop            = 1'b0;
        clear_ras      = 1'b0;
        redirect_next  = 1'b0;
        misalign_next  = 1'b0;
        underflow_next = 1'b0;

        if (exc) begin
            pc_next       = EXC_VECTOR;
            redirect_next = 1'b1;
        end else if (!stall) begin
            case (op_cmd)
                OP_SEQ: begin
                    pc_next = pc_seq;
                end
                OP_BRANCH: begin
                    dest       = pc + offset;
                    check_dest = 1'b1;
                end
                OP_JUMP: begin
                    dest       = target;
                    check_dest = 1'b1;
                end
                OP_CALL: begin
                    dest       = target;
                    check_dest = 1'b1;
                    push_req   = 1'b1;
                end
                OP_RET: begin
                    check_dest = 1'b1;
                    if (ras_count != '0) begin
                        dest = ras_mem[ras_top];
                        pop  = 1'b1;
                    end else begin
                        dest           = target;
                        underflow_next = 1'b1;
                    end
                end
                OP_RELOAD: begin
                    pc_next       = RESET_VECTOR;
                    clear_ras     = 1'b1;
                    redirect_next = 1'b1;
                end
                OP_HOLD, OP_RESERVED: begin
                    pc_next = pc;
                end
                default: begin
                    pc_next = pc;
                end
            endcase

            // A misaligned destination vectors to the exception handler; a misaligned
            // RET has already consumed its entry, but a misaligned CALL must not push.
            if (check_dest) begin
                redirect_next = 1'b1;
                if ((dest & ALIGN_MASK) != '0) begin
                    pc_next       = EXC_VECTOR;
                    misalign_next = 1'b1;
                end else begin
                    pc_next = dest;
                end
            end
            push = push_req && !misalign_next;
        end
    end

    always_comb begin
        top_next   = ras_top;
        count_next = ras_count;
        if (clear_ras) begin
            top_next   = '0;
            count_next = '0;
        end else if (push) begin
            top_next = top_inc;
            if (ras_count != CW'(RAS_DEPTH)) begin
                count_next = ras_count + 1'b1;
            end
        end else if (pop) begin
            top_next   = top_dec;
            count_next = ras_count - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc            <= RESET_VECTOR;
            ras_top       <= '0;
            ras_count     <= '0;
            redirect      <= 1'b0;
            misalign      <= 1'b0;
            ras_underflow <= 1'b0;
        end else begin
            pc            <= pc_next;
            ras_top       <= top_next;
            ras_count     <= count_next;
            redirect      <= redirect_next;
            misalign      <= misalign_next;
            ras_underflow <= underflow_next;
        end
    end

    // Stack storage needs no reset; only entries counted by ras_count are ever read.
    always_ff @(posedge clk) begin
        if (push) begin
            ras_mem[top_inc] <= pc_seq;
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: a queue-based reference model of the sequencing
// rules is compared against the DUT on every falling edge, plus literal spot checks.
module tb_pc_sequencer;

    localparam int          DEPTH = 4;
    localparam logic [31:0] EXC   = 32'h80;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  op;
    logic        stall;
    logic        exc;
    logic [31:0] offset;
    logic [31:0] target;
    logic [31:0] pc;
    logic [31:0] pc_seq;
    logic        redirect;
    logic        misalign;
    logic        ras_underflow;
    logic [2:0]  ras_count;

    int checks = 0;
    int errors = 0;
    bit check_en = 1'b0;

    logic [31:0] m_pc;
    logic [31:0] m_ras[$];
    bit          m_redirect;
    bit          m_misalign;
    bit          m_underflow;

    pc_sequencer #(
        .WIDTH(32), .INSTR_BYTES(4), .RESET_VECTOR(32'h0),
        .EXC_VECTOR(EXC), .RAS_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst(rst), .op(op), .stall(stall), .exc(exc),
        .offset(offset), .target(target), .pc(pc), .pc_seq(pc_seq),
        .redirect(redirect), .misalign(misalign),
        .ras_underflow(ras_underflow), .ras_count(ras_count)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic compare(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic modelReset();
        m_pc        = 32'h0;
        m_ras.delete();
        m_redirect  = 1'b0;
        m_misalign  = 1'b0;
        m_underflow = 1'b0;
    endtask

    // Reference behaviour: RAS is an unbounded queue trimmed from the oldest end.
    task automatic modelStep(input logic [2:0] o, input bit st, input bit ex,
                             input logic [31:0] off, input logic [31:0] tgt);
        logic [31:0] dest;
        bit go;
        go          = 1'b0;
        dest        = 32'h0;
        m_redirect  = 1'b0;
        m_misalign  = 1'b0;
        m_underflow = 1'b0;
        if (ex) begin
            m_pc       = EXC;
            m_redirect = 1'b1;
        end else if (!st) begin
            case (o)
                3'd0: m_pc = m_pc + 32'd4;
                3'd1: begin dest = m_pc + off; go = 1'b1; end
                3'd2: begin dest = tgt; go = 1'b1; end
                3'd3: begin
                    dest = tgt;
                    go   = 1'b1;
                    if (tgt % 4 == 0) begin
                        m_ras.push_back(m_pc + 32'd4);
                        if (m_ras.size() > DEPTH) void'(m_ras.pop_front());
                    end
                end
                3'd4: begin
                    go = 1'b1;
                    if (m_ras.size() > 0) dest = m_ras.pop_back();
                    else begin dest = tgt; m_underflow = 1'b1; end
                end
                3'd6: begin m_pc = 32'h0; m_ras.delete(); m_redirect = 1'b1; end
                default: ;
            endcase
            if (go) begin
                m_redirect = 1'b1;
                if (dest % 4 != 0) begin m_pc = EXC; m_misalign = 1'b1; end
                else m_pc = dest;
            end
        end
    endtask

    task automatic checkOutput();
        compare("pc", pc, m_pc);
        compare("pc_seq", pc_seq, m_pc + 32'd4);
        compare("redirect", {31'b0, redirect}, {31'b0, m_redirect});
        compare("misalign", {31'b0, misalign}, {31'b0, m_misalign});
        compare("ras_underflow", {31'b0, ras_underflow}, {31'b0, m_underflow});
        compare("ras_count", {29'b0, ras_count}, m_ras.size());
    endtask

    always @(negedge clk) begin
        if (check_en) checkOutput();
    end

    task automatic applyStimulus(input logic [2:0] o, input bit st, input bit ex,
                                 input logic [31:0] off, input logic [31:0] tgt);
        op = o; stall = st; exc = ex; offset = off; target = tgt;
        modelStep(o, st, ex, off, tgt);
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic cmd(input logic [2:0] o, input logic [31:0] tgt);
        applyStimulus(o, 1'b0, 1'b0, 32'h0, tgt);
    endtask

    initial begin
        rst = 1'b1; op = 3'd0; stall = 1'b0; exc = 1'b0; offset = '0; target = '0;
        modelReset();
        #3;
        compare("reset pc", pc, 32'h0);
        compare("reset pc_seq", pc_seq, 32'h4);
        compare("reset ras_count", {29'b0, ras_count}, 32'h0);
        compare("reset pulses", {29'b0, redirect, misalign, ras_underflow}, 32'h0);
        @(negedge clk); #1;
        rst = 1'b0;
        check_en = 1'b1;

        cmd(3'd0, 0); compare("seq1", pc, 32'h4);
        cmd(3'd0, 0); compare("seq2", pc, 32'h8);
        cmd(3'd0, 0); compare("seq3", pc, 32'hC);
        compare("seq redirect", {31'b0, redirect}, 32'h0);

        // Asynchronous reset mid-cycle, well away from any clock edge.
        #1; rst = 1'b1; modelReset(); #1;
        compare("async reset pc", pc, 32'h0);
        compare("async reset pc_seq", pc_seq, 32'h4);
        @(negedge clk); #1; rst = 1'b0;

        cmd(3'd2, 32'h100);
        applyStimulus(3'd1, 1'b0, 1'b0, 32'hFFFF_FFF0, 32'h0);
        compare("branch back pc", pc, 32'hF0);
        compare("branch redirect", {31'b0, redirect}, 32'h1);
        cmd(3'd0, 0); compare("seq after branch", pc, 32'hF4);

        cmd(3'd2, 32'h40);
        cmd(3'd3, 32'h200); compare("call1 count", {29'b0, ras_count}, 32'h1);
        cmd(3'd3, 32'h300); compare("call2 count", {29'b0, ras_count}, 32'h2);
        cmd(3'd4, 32'h0);   compare("ret1 pc", pc, 32'h204);
        cmd(3'd4, 32'h0);   compare("ret2 pc", pc, 32'h44);
        cmd(3'd4, 32'h500); compare("ret underflow pc", pc, 32'h500);
        compare("ret underflow flag", {31'b0, ras_underflow}, 32'h1);

        cmd(3'd6, 0);
        for (int i = 0; i < 5; i++) cmd(3'd3, 32'h10 * (i + 1));
        compare("ras full count", {29'b0, ras_count}, 32'h4);
        cmd(3'd4, 0); compare("deep ret1", pc, 32'h44);
        cmd(3'd4, 0); compare("deep ret2", pc, 32'h34);
        cmd(3'd4, 0); compare("deep ret3", pc, 32'h24);
        cmd(3'd4, 0); compare("deep ret4", pc, 32'h14);
        cmd(3'd4, 32'h700); compare("deep underflow", {31'b0, ras_underflow}, 32'h1);

        cmd(3'd2, 32'h202);
        compare("misalign jump pc", pc, 32'h80);
        compare("misalign flag", {31'b0, misalign}, 32'h1);
        cmd(3'd3, 32'h100);
        cmd(3'd3, 32'h3);
        compare("misalign call pc", pc, 32'h80);
        compare("misalign call count", {29'b0, ras_count}, 32'h1);
        applyStimulus(3'd1, 1'b0, 1'b0, 32'h6, 32'h0);
        compare("misalign branch pc", pc, 32'h80);

        cmd(3'd5, 0);
        cmd(3'd7, 0);
        compare("hold pc", pc, 32'h80);
        applyStimulus(3'd2, 1'b1, 1'b0, 32'h0, 32'h400);
        compare("stall pc", pc, 32'h80);
        cmd(3'd2, 32'h10);
        applyStimulus(3'd2, 1'b1, 1'b1, 32'h0, 32'h400);
        compare("stall exc pc", pc, 32'h80);
        applyStimulus(3'd3, 1'b0, 1'b1, 32'h0, 32'h400);
        compare("exc keeps ras", {29'b0, ras_count}, 32'h1);

        cmd(3'd2, 32'hFFFF_FFFC);
        compare("top pc_seq wrap", pc_seq, 32'h0);
        cmd(3'd0, 0); compare("seq wrap", pc, 32'h0);
        cmd(3'd6, 0);
        compare("reload pc", pc, 32'h0);
        compare("reload count", {29'b0, ras_count}, 32'h0);
        cmd(3'd0, 0);

        check_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
